// File: rtl/sevenseg_scan_decoder.sv
// Reconstructs the hex word and decimal points shown on a scanned seven-segment display
// by snooping its active-low anode/cathode lines; a digit is captured once its pattern is stable.
module sevenseg_scan_decoder #(
    parameter int unsigned NDIGITS    = 8,
    parameter int unsigned STABLE_CYC = 4
) (
    input  logic                   CLK,
    input  logic                   RES,
    input  logic [NDIGITS-1:0]     AN,
    input  logic [7:0]             CAT,
    input  logic                   CLR,
    output logic [NDIGITS-1:0]     DVALID,
    output logic                   FRAME,
    output logic [4*NDIGITS-1:0]   FVALUE,
    output logic [NDIGITS-1:0]     FPOINT,
    output logic                   ERR,
    output logic [6:0]             ERR_PAT,
    output logic [7:0]             ERR_CNT
);

    localparam logic [7:0] stab_max = 8'(STABLE_CYC);

    logic [NDIGITS-1:0]   samp_an, prev_an;
    logic [7:0]           samp_cat, prev_cat;
    logic [7:0]           stab_cnt, stab_nxt;
    logic [4*NDIGITS-1:0] part_val, pv_nxt;
    logic [NDIGITS-1:0]   part_dp, pd_nxt;
    logic [NDIGITS-1:0]   sel, dv_nxt;
    logic                 single, same, capture, hit;
    logic [3:0]           nib;

    always_comb begin
        hit = 1'b1;
        nib = '0;
        case (samp_cat[6:0])
            7'b1000000: nib = 4'h0;
            7'b1111001: nib = 4'h1;
            7'b0100100: nib = 4'h2;
            7'b0110000: nib = 4'h3;
            7'b0011001: nib = 4'h4;
            7'b0010010: nib = 4'h5;
            7'b0000010: nib = 4'h6;
            7'b1111000: nib = 4'h7;
            7'b0000000: nib = 4'h8;
            7'b0010000: nib = 4'h9;
            7'b0001000: nib = 4'hA;
            7'b0000011: nib = 4'hB;
            7'b1000110: nib = 4'hC;
            7'b0100001: nib = 4'hD;
            7'b0000110: nib = 4'hE;
            7'b0001110: nib = 4'hF;
            default:    hit = 1'b0;
        endcase
    end

    always_comb begin
        sel    = ~samp_an;
        single = (sel != '0) && ((sel & (sel - NDIGITS'(1))) == '0);
        same   = (samp_an == prev_an) && (samp_cat == prev_cat);

        if (!single)
            stab_nxt = '0;
        else if (!same)
            stab_nxt = 8'd1;
        else if (stab_cnt == stab_max)
            stab_nxt = stab_cnt;
        else
            stab_nxt = stab_cnt + 8'd1;

        // A saturated counter on an unchanged pair means this dwell was already captured.
        capture = single && (stab_nxt == stab_max) && (!same || (stab_cnt != stab_max));

        pv_nxt = part_val;
        pd_nxt = part_dp;
        for (int unsigned i = 0; i < NDIGITS; i++) begin
            if (sel[i]) begin
                pv_nxt[4*i +: 4] = nib;
                pd_nxt[i]        = ~samp_cat[7];
            end
        end
        dv_nxt = DVALID | sel;
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            samp_an  <= '0;
            samp_cat <= '0;
            prev_an  <= '0;
            prev_cat <= '0;
            stab_cnt <= '0;
            part_val <= '0;
            part_dp  <= '0;
            DVALID   <= '0;
            FRAME    <= 1'b0;
            FVALUE   <= '0;
            FPOINT   <= '0;
            ERR      <= 1'b0;
            ERR_PAT  <= '0;
            ERR_CNT  <= '0;
        end else begin
            samp_an  <= AN;
            samp_cat <= CAT;
            prev_an  <= samp_an;
            prev_cat <= samp_cat;
            stab_cnt <= stab_nxt;
            FRAME    <= 1'b0;
            ERR      <= 1'b0;

            if (capture && !hit) begin
                ERR     <= 1'b1;
                ERR_PAT <= samp_cat[6:0];
                if (ERR_CNT != '1)
                    ERR_CNT <= ERR_CNT + 8'd1;
            end

            // Clear takes priority over both the error count and a coincident capture.
            if (CLR) begin
                DVALID  <= '0;
                ERR_CNT <= '0;
            end else if (capture && hit) begin
                part_val <= pv_nxt;
                part_dp  <= pd_nxt;
                if (&dv_nxt) begin
                    FVALUE <= pv_nxt;
                    FPOINT <= pd_nxt;
                    FRAME  <= 1'b1;
                    DVALID <= '0;
                end else begin
                    DVALID <= dv_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Directed, table-driven checks of sevenseg_scan_decoder with 4 digits and a 4-sample
// stability window, plus hand-written multi-cycle sequences for frame timing, clear and reset.
module tb_sevenseg_scan_decoder;

    logic        CLK = 1'b0;
    logic        RES;
    logic [3:0]  AN;
    logic [7:0]  CAT;
    logic        CLR;
    logic [3:0]  DVALID;
    logic        FRAME;
    logic [15:0] FVALUE;
    logic [3:0]  FPOINT;
    logic        ERR;
    logic [6:0]  ERR_PAT;
    logic [7:0]  ERR_CNT;

    sevenseg_scan_decoder #(.NDIGITS(4), .STABLE_CYC(4)) dut (
        .CLK(CLK), .RES(RES), .AN(AN), .CAT(CAT), .CLR(CLR),
        .DVALID(DVALID), .FRAME(FRAME), .FVALUE(FVALUE), .FPOINT(FPOINT),
        .ERR(ERR), .ERR_PAT(ERR_PAT), .ERR_CNT(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int frames   = 0;
    int errs     = 0;

    always @(negedge CLK) begin
        if (FRAME) frames++;
        if (ERR)   errs++;
    end

    typedef struct {
        logic [3:0]  an;
        logic [7:0]  cat;
        int          ncyc;
        logic [3:0]  dv;
        int          frames;
        int          errs;
        logic [7:0]  ecnt;
        logic [6:0]  epat;
        logic [15:0] fval;
        logic [3:0]  fpt;
    } vec_t;

    vec_t vecs [16];

    // Active-low cathode pattern for hex value v, CAT[7] low when the point is lit.
    function automatic logic [7:0] seg(input int v, input logic dp);
        logic [6:0] g;
        case (v)
            0:  g = 7'b1000000;  1:  g = 7'b1111001;  2:  g = 7'b0100100;  3:  g = 7'b0110000;
            4:  g = 7'b0011001;  5:  g = 7'b0010010;  6:  g = 7'b0000010;  7:  g = 7'b1111000;
            8:  g = 7'b0000000;  9:  g = 7'b0010000;  10: g = 7'b0001000;  11: g = 7'b0000011;
            12: g = 7'b1000110;  13: g = 7'b0100001;  14: g = 7'b0000110;  default: g = 7'b0001110;
        endcase
        return {~dp, g};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic [3:0] an, input logic [7:0] cat, input int n);
        AN  = an;
        CAT = cat;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dvalid"}, 32'(DVALID), 32'h0);
        check({tag, "_frame"},  32'(FRAME),  32'h0);
        check({tag, "_fvalue"}, 32'(FVALUE), 32'h0);
        check({tag, "_fpoint"}, 32'(FPOINT), 32'h0);
        check({tag, "_err"},    32'(ERR),    32'h0);
        check({tag, "_errpat"}, 32'(ERR_PAT), 32'h0);
        check({tag, "_errcnt"}, 32'(ERR_CNT), 32'h0);
    endtask

    initial begin
        int f0, e0;

        vecs[0]  = '{4'b1110, seg(1, 0),  10, 4'b0001, 0, 0, 8'd0, 7'h00, 16'h0000, 4'b0000};
        vecs[1]  = '{4'b1101, seg(2, 0),  10, 4'b0011, 0, 0, 8'd0, 7'h00, 16'h0000, 4'b0000};
        vecs[2]  = '{4'b1011, seg(3, 1),  10, 4'b0111, 0, 0, 8'd0, 7'h00, 16'h0000, 4'b0000};
        vecs[3]  = '{4'b0111, seg(4, 0),  10, 4'b0000, 1, 0, 8'd0, 7'h00, 16'h4321, 4'b0100};
        vecs[4]  = '{4'b0011, seg(8, 0),  20, 4'b0000, 1, 0, 8'd0, 7'h00, 16'h4321, 4'b0100};
        vecs[5]  = '{4'b1111, seg(8, 0),   5, 4'b0000, 1, 0, 8'd0, 7'h00, 16'h4321, 4'b0100};
        vecs[6]  = '{4'b1110, seg(0, 0),   3, 4'b0000, 1, 0, 8'd0, 7'h00, 16'h4321, 4'b0100};
        vecs[7]  = '{4'b1111, seg(0, 0),   3, 4'b0000, 1, 0, 8'd0, 7'h00, 16'h4321, 4'b0100};
        vecs[8]  = '{4'b1110, seg(0, 0),   4, 4'b0000, 1, 0, 8'd0, 7'h00, 16'h4321, 4'b0100};
        vecs[9]  = '{4'b1111, seg(0, 0),   3, 4'b0001, 1, 0, 8'd0, 7'h00, 16'h4321, 4'b0100};
        vecs[10] = '{4'b1101, 8'hFF,      10, 4'b0001, 1, 1, 8'd1, 7'h7F, 16'h4321, 4'b0100};
        vecs[11] = '{4'b1101, 8'hBF,      10, 4'b0001, 1, 2, 8'd2, 7'h3F, 16'h4321, 4'b0100};
        vecs[12] = '{4'b1101, seg(10, 0), 10, 4'b0011, 1, 2, 8'd2, 7'h3F, 16'h4321, 4'b0100};
        vecs[13] = '{4'b1101, seg(11, 0), 10, 4'b0011, 1, 2, 8'd2, 7'h3F, 16'h4321, 4'b0100};
        vecs[14] = '{4'b0111, seg(15, 0), 10, 4'b1011, 1, 2, 8'd2, 7'h3F, 16'h4321, 4'b0100};
        vecs[15] = '{4'b1011, seg(12, 1), 10, 4'b0000, 2, 2, 8'd2, 7'h3F, 16'hFCB0, 4'b0100};

        RES = 1'b1;
        CLR = 1'b0;
        AN  = 4'b1111;
        CAT = 8'hFF;
        repeat (3) @(posedge CLK);
        #1;
        RES = 1'b0;
        check_all_zero("reset");

        foreach (vecs[i]) begin
            hold(vecs[i].an, vecs[i].cat, vecs[i].ncyc);
            check($sformatf("vec%0d_dvalid", i), 32'(DVALID),  32'(vecs[i].dv));
            check($sformatf("vec%0d_frames", i), 32'(frames),  32'(vecs[i].frames));
            check($sformatf("vec%0d_errs", i),   32'(errs),    32'(vecs[i].errs));
            check($sformatf("vec%0d_errcnt", i), 32'(ERR_CNT), 32'(vecs[i].ecnt));
            check($sformatf("vec%0d_errpat", i), 32'(ERR_PAT), 32'(vecs[i].epat));
            check($sformatf("vec%0d_fvalue", i), 32'(FVALUE),  32'(vecs[i].fval));
            check($sformatf("vec%0d_fpoint", i), 32'(FPOINT),  32'(vecs[i].fpt));
        end

        // Frame strobe lands on the fifth edge of the completing dwell.
        hold(4'b1110, seg(5, 0), 10);
        hold(4'b1101, seg(6, 0), 10);
        hold(4'b1011, seg(7, 0), 10);
        AN  = 4'b0111;
        CAT = seg(9, 0);
        for (int k = 1; k <= 6; k++) begin
            @(posedge CLK);
            #1;
            check($sformatf("ftime_edge%0d", k), 32'(FRAME), (k == 5) ? 32'h1 : 32'h0);
            if (k == 5) check("ftime_dvalid", 32'(DVALID), 32'h0);
        end
        hold(4'b1111, 8'hFF, 3);
        check("ftime_fvalue", 32'(FVALUE), 32'h9765);
        check("ftime_fpoint", 32'(FPOINT), 32'h0);
        check("ftime_frames", 32'(frames), 32'd3);

        // Standalone clear.
        hold(4'b1110, seg(2, 0), 10);
        check("clr_pre_dvalid", 32'(DVALID), 32'b0001);
        AN  = 4'b1111;
        CLR = 1'b1;
        @(posedge CLK);
        #1;
        CLR = 1'b0;
        check("clr_dvalid", 32'(DVALID), 32'h0);
        check("clr_errcnt", 32'(ERR_CNT), 32'h0);
        check("clr_fvalue", 32'(FVALUE), 32'h9765);

        // Error counter saturation.
        e0 = errs;
        for (int i = 0; i < 300; i++)
            hold(4'b1101, (i % 2 == 1) ? 8'hBF : 8'hFF, 5);
        hold(4'b1111, 8'hFF, 3);
        check("sat_errcnt", 32'(ERR_CNT), 32'd255);
        check("sat_errs",   32'(errs - e0), 32'd300);
        check("sat_errpat", 32'(ERR_PAT), 32'h3F);

        // Clear coinciding with an error event.
        e0 = errs;
        hold(4'b1101, 8'hFF, 4);
        CLR = 1'b1;
        @(posedge CLK);
        #1;
        CLR = 1'b0;
        check("clrerr_err", 32'(ERR), 32'h1);
        hold(4'b1111, 8'hFF, 3);
        check("clrerr_errcnt", 32'(ERR_CNT), 32'h0);
        check("clrerr_errs",   32'(errs - e0), 32'd1);

        // Clear coinciding with the completing capture.
        f0 = frames;
        hold(4'b1110, seg(1, 0), 10);
        hold(4'b1101, seg(2, 0), 10);
        hold(4'b1011, seg(3, 0), 10);
        check("clrcap_pre_dvalid", 32'(DVALID), 32'b0111);
        hold(4'b0111, seg(4, 0), 4);
        CLR = 1'b1;
        @(posedge CLK);
        #1;
        CLR = 1'b0;
        check("clrcap_frame",  32'(FRAME),  32'h0);
        check("clrcap_dvalid", 32'(DVALID), 32'h0);
        hold(4'b1111, 8'hFF, 5);
        check("clrcap_frames", 32'(frames - f0), 32'd0);
        check("clrcap_fvalue", 32'(FVALUE), 32'h9765);
        check("clrcap_dvalid2", 32'(DVALID), 32'h0);

        // Reset in the middle of the last digit's dwell.
        hold(4'b1101, 8'hFF, 10);
        check("rst_pre_errcnt", 32'(ERR_CNT), 32'd1);
        hold(4'b1110, seg(10, 1), 10);
        hold(4'b1101, seg(11, 0), 10);
        hold(4'b1011, seg(12, 0), 10);
        f0 = frames;
        hold(4'b0111, seg(13, 0), 3);
        RES = 1'b1;
        @(posedge CLK);
        #1;
        RES = 1'b0;
        check_all_zero("midrst");
        hold(4'b0111, seg(13, 0), 10);
        check("rst_d3_dvalid", 32'(DVALID), 32'b1000);
        check("rst_d3_frames", 32'(frames - f0), 32'd0);
        hold(4'b1110, seg(10, 0), 10);
        hold(4'b1101, seg(11, 0), 10);
        check("rst_part_frames", 32'(frames - f0), 32'd0);
        hold(4'b1011, seg(12, 0), 10);
        check("rst_frames", 32'(frames - f0), 32'd1);
        check("rst_fvalue", 32'(FVALUE), 32'hDCBA);
        check("rst_fpoint", 32'(FPOINT), 32'h0);
        check("rst_dvalid", 32'(DVALID), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
